// File: rtl/camellia_stream_driver.sv
// Streams four 32-bit host words into a 128-bit cipher core block, launches the core,
// waits (bounded) for its result and streams the result back out as four 32-bit words.
module camellia_stream_driver #(
    parameter int TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_mode,
    input  logic [127:0] key,
    output logic [127:0] core_in,
    output logic [127:0] core_kl,
    output logic         core_control,
    output logic         core_data_valid,
    input  logic [127:0] core_out,
    input  logic         core_rdy,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy,
    output logic         timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [1:0]     in_cnt_r;
    logic [1:0]     out_cnt_r;
    logic [CW-1:0]  wait_cnt_r;
    logic [127:0]   result_r;
    logic [127:0]   core_in_r;
    logic [127:0]   core_kl_r;
    logic           core_control_r;
    logic           core_data_valid_r;
    logic [31:0]    m_data_r;
    logic           m_valid_r;
    logic           s_ready_r;
    logic           busy_r;
    logic           timeout_err_r;
    logic           in_fire_s;
    logic           out_fire_s;
    logic           wait_done_s;

    // Word 0 is the most significant word of a block.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
        case (idx)
            2'd0:    word_sel = blk[127:96];
            2'd1:    word_sel = blk[95:64];
            2'd2:    word_sel = blk[63:32];
            default: word_sel = blk[31:0];
        endcase
    endfunction

    assign in_fire_s   = s_valid && s_ready_r && (state_r == LOAD);
    assign out_fire_s  = m_valid_r && m_ready && (state_r == DRAIN);
    // The WAIT cycle that carries this count is the last one allowed.
    assign wait_done_s = (wait_cnt_r == CW'(TIMEOUT - 1));

    // Next-state logic; a result arriving on the final WAIT cycle beats the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (in_fire_s && (in_cnt_r == 2'd3)) state_nxt_s = LAUNCH;
                else                                 state_nxt_s = LOAD;
            end
            LAUNCH: state_nxt_s = WAIT;
            WAIT: begin
                if (core_rdy)         state_nxt_s = DRAIN;
                else if (wait_done_s) state_nxt_s = LOAD;
                else                  state_nxt_s = WAIT;
            end
            DRAIN: begin
                if (out_fire_s && (out_cnt_r == 2'd3)) state_nxt_s = LOAD;
                else                                   state_nxt_s = DRAIN;
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State register and handshake/status outputs, all registered from the next state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r           <= LOAD;
            s_ready_r         <= 1'b0;
            busy_r            <= 1'b0;
            core_data_valid_r <= 1'b0;
            m_valid_r         <= 1'b0;
            wait_cnt_r        <= '0;
            timeout_err_r     <= 1'b0;
        end else begin
            state_r           <= state_nxt_s;
            s_ready_r         <= (state_nxt_s == LOAD);
            busy_r            <= (state_nxt_s != LOAD);
            core_data_valid_r <= (state_nxt_s == LAUNCH);
            m_valid_r         <= (state_nxt_s == DRAIN);
            wait_cnt_r        <= (state_r == WAIT) ? (wait_cnt_r + CW'(1)) : '0;
            if ((state_r == LOAD) && (state_nxt_s == LAUNCH)) begin
                timeout_err_r <= 1'b0;
            end else if ((state_r == WAIT) && !core_rdy && wait_done_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    // Datapath: block assembly, key capture, result capture and output word stepping.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            in_cnt_r       <= 2'd0;
            out_cnt_r      <= 2'd0;
            core_in_r      <= 128'd0;
            core_kl_r      <= 128'd0;
            core_control_r <= 1'b0;
            result_r       <= 128'd0;
            m_data_r       <= 32'd0;
        end else begin
            if (in_fire_s) begin
                in_cnt_r <= in_cnt_r + 2'd1;
                case (in_cnt_r)
                    2'd0:    core_in_r[127:96] <= s_data;
                    2'd1:    core_in_r[95:64]  <= s_data;
                    2'd2:    core_in_r[63:32]  <= s_data;
                    default: core_in_r[31:0]   <= s_data;
                endcase
                if (in_cnt_r == 2'd0) core_control_r <= s_mode;
            end
            if ((state_r == LOAD) && (state_nxt_s == LAUNCH)) begin
                core_kl_r <= key;
            end
            if ((state_r == WAIT) && core_rdy) begin
                result_r  <= core_out;
                m_data_r  <= core_out[127:96];
                out_cnt_r <= 2'd0;
            end else if (out_fire_s) begin
                out_cnt_r <= out_cnt_r + 2'd1;
                m_data_r  <= word_sel(result_r, out_cnt_r + 2'd1);
            end
        end
    end

    assign s_ready         = s_ready_r;
    assign busy            = busy_r;
    assign core_in         = core_in_r;
    assign core_kl         = core_kl_r;
    assign core_control    = core_control_r;
    assign core_data_valid = core_data_valid_r;
    assign m_data          = m_data_r;
    assign m_valid         = m_valid_r;
    assign timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_camellia_stream_driver.sv
// Self-checking bench for camellia_stream_driver: a reversible toy cipher core model and
// block-level expectations computed from the host-visible word order.
module tb_camellia_stream_driver;

    localparam int T = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [31:0]  s_data = 32'd0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_mode = 1'b0;
    logic [127:0] key = 128'd0;
    logic [127:0] core_in;
    logic [127:0] core_kl;
    logic         core_control;
    logic         core_data_valid;
    logic [127:0] core_out = 128'd0;
    logic         core_rdy = 1'b0;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         busy;
    logic         timeout_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    camellia_stream_driver #(.TIMEOUT(T)) dut (
        .CLK(CLK), .RST(RST),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
        .key(key),
        .core_in(core_in), .core_kl(core_kl), .core_control(core_control),
        .core_data_valid(core_data_valid),
        .core_out(core_out), .core_rdy(core_rdy),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Toy invertible cipher: encrypt = rotl13 then xor key; decrypt undoes it.
    function automatic logic [127:0] core_model(input logic [127:0] blk, input logic [127:0] k,
                                                input logic mode);
        logic [127:0] y;
        if (mode == 1'b0) begin
            core_model = {blk[114:0], blk[127:115]} ^ k;
        end else begin
            y = blk ^ k;
            core_model = {y[12:0], y[127:13]};
        end
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] v, input int i);
        return v[127 - 32*i -: 32];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_words(input logic [127:0] blk, input logic mode, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            int guard;
            guard   = 0;
            s_data  = word_of(blk, w);
            s_mode  = (w == 0) ? mode : 1'($urandom_range(0, 1));
            s_valid = 1'b1;
            while (s_ready !== 1'b1 && guard < 40) begin
                tick();
                guard++;
            end
            total_cnt++;
            if (guard >= 40) $display("FAIL send_word%0d: s_ready=%b never rose, required 1", w, s_ready);
            else pass_cnt++;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic do_block(input logic [127:0] blk, input logic mode, input logic [127:0] k,
                            input int lat, input int stall_word, input int stall_len);
        logic [127:0] exp_res;
        exp_res = core_model(blk, k, mode);
        key = k;
        core_rdy = 1'b1; core_out = rand128();
        tick();
        core_rdy = 1'b0;
        total_cnt++;
        if ({s_ready, busy, m_valid, core_data_valid} !== 4'b1000)
            $display("FAIL spur_load: rdy/busy/mv/cdv=%b required 1000", {s_ready, busy, m_valid, core_data_valid});
        else pass_cnt++;

        send_words(blk, mode, 4);
        total_cnt++;
        if ({core_data_valid, s_ready, busy} !== 3'b101)
            $display("FAIL launch_ctl: cdv/rdy/busy=%b required 101", {core_data_valid, s_ready, busy});
        else pass_cnt++;
        total_cnt++;
        if ({core_in, core_kl, core_control} !== {blk, k, mode})
            $display("FAIL launch_data: core_in=%h kl=%h ctl=%b required %h %h %b", core_in, core_kl, core_control, blk, k, mode);
        else pass_cnt++;
        tick();
        key = rand128();
        total_cnt++;
        if ({core_data_valid, timeout_err, m_valid, s_ready} !== 4'b0000)
            $display("FAIL wait_entry: cdv/terr/mv/rdy=%b required 0000", {core_data_valid, timeout_err, m_valid, s_ready});
        else pass_cnt++;

        for (int i = 0; i < lat; i++) begin
            total_cnt++;
            if ({core_in, core_kl, core_control, m_valid, core_data_valid} !== {blk, k, mode, 2'b00})
                $display("FAIL wait_stable: core_in=%h kl=%h ctl=%b mv=%b cdv=%b required %h %h %b 0 0",
                         core_in, core_kl, core_control, m_valid, core_data_valid, blk, k, mode);
            else pass_cnt++;
            tick();
        end
        core_rdy = 1'b1; core_out = exp_res;
        tick();
        core_rdy = 1'b0; core_out = rand128();
        total_cnt++;
        if ({m_valid, s_ready, busy, timeout_err} !== 4'b1010)
            $display("FAIL drain_entry: mv/rdy/busy/terr=%b required 1010", {m_valid, s_ready, busy, timeout_err});
        else pass_cnt++;

        for (int j = 0; j < 4; j++) begin
            if (j == stall_word) begin
                m_ready = 1'b0;
                for (int c = 0; c < stall_len; c++) begin
                    core_rdy = 1'($urandom_range(0, 1)); core_out = rand128();
                    total_cnt++;
                    if ({m_valid, s_ready, m_data} !== {2'b10, word_of(exp_res, j)})
                        $display("FAIL stall_w%0d_c%0d: mv=%b rdy=%b m_data=%h required 1 0 %h",
                                 j, c, m_valid, s_ready, m_data, word_of(exp_res, j));
                    else pass_cnt++;
                    tick();
                end
                core_rdy = 1'b0;
            end
            m_ready = 1'b1;
            total_cnt++;
            if ({m_valid, m_data} !== {1'b1, word_of(exp_res, j)})
                $display("FAIL out_word%0d: mv=%b m_data=%h required 1 %h", j, m_valid, m_data, word_of(exp_res, j));
            else pass_cnt++;
            tick();
            m_ready = 1'b0;
        end
        total_cnt++;
        if ({m_valid, s_ready, busy} !== 3'b010)
            $display("FAIL back_to_load: mv/rdy/busy=%b required 010", {m_valid, s_ready, busy});
        else pass_cnt++;
    endtask

    task automatic check_all_zero(input string tag);
        total_cnt++;
        if ({s_ready, m_valid, core_data_valid, busy, timeout_err, core_control} !== 6'd0 ||
            core_in !== 128'd0 || core_kl !== 128'd0 || m_data !== 32'd0)
            $display("FAIL %s: ctl bits=%b core_in=%h kl=%h m_data=%h required all 0", tag,
                     {s_ready, m_valid, core_data_valid, busy, timeout_err, core_control}, core_in, core_kl, m_data);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_state");
        RST = 1'b1;
        tick();
        total_cnt++;
        if ({s_ready, busy} !== 2'b10) $display("FAIL reset_release: rdy/busy=%b required 10", {s_ready, busy});
        else pass_cnt++;
    endtask

    task automatic test_encrypt();
        logic [127:0] pt;
        pt = 128'h0123456789ABCDEFFEDCBA9876543210;
        do_block(pt, 1'b0, pt, 2, -1, 0);
    endtask

    task automatic test_decrypt();
        logic [127:0] pt;
        pt = 128'h0123456789ABCDEFFEDCBA9876543210;
        do_block(core_model(pt, pt, 1'b0), 1'b1, pt, 0, -1, 0);
    endtask

    task automatic test_backpressure();
        do_block(rand128(), 1'($urandom_range(0, 1)), rand128(), 1, 1, 5);
    endtask

    task automatic test_timeout();
        send_words(rand128(), 1'b0, 4);
        total_cnt++;
        if (core_data_valid !== 1'b1) $display("FAIL to_launch: cdv=%b required 1", core_data_valid);
        else pass_cnt++;
        tick();
        for (int i = 0; i < T; i++) begin
            total_cnt++;
            if ({timeout_err, m_valid, busy} !== 3'b001)
                $display("FAIL to_wait%0d: terr/mv/busy=%b required 001", i, {timeout_err, m_valid, busy});
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({timeout_err, m_valid, busy, s_ready} !== 4'b1001)
            $display("FAIL to_expired: terr/mv/busy/rdy=%b required 1001", {timeout_err, m_valid, busy, s_ready});
        else pass_cnt++;
        // Next block must clear the sticky flag (checked at WAIT entry) and complete.
        do_block(rand128(), 1'b1, rand128(), 3, -1, 0);
    endtask

    task automatic test_capture_at_limit();
        do_block(rand128(), 1'b0, rand128(), T - 1, 3, 2);
    endtask

    task automatic test_reset_mid_block();
        send_words(rand128(), 1'b1, 2);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        do_block(rand128(), 1'b0, rand128(), 0, -1, 0);

        send_words(rand128(), 1'b1, 4);
        tick();
        tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check_all_zero("reset_mid_wait");
        core_rdy = 1'b1; core_out = rand128();
        tick();
        core_rdy = 1'b0;
        total_cnt++;
        if ({s_ready, m_valid, core_data_valid, busy} !== 4'b1000)
            $display("FAIL post_reset_rdy: rdy/mv/cdv/busy=%b required 1000", {s_ready, m_valid, core_data_valid, busy});
        else pass_cnt++;
        do_block(rand128(), 1'b1, rand128(), 2, -1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            do_block(rand128(), 1'($urandom_range(0, 1)), rand128(), $urandom_range(0, T - 1),
                     $urandom_range(0, 4), $urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_timeout();
        test_capture_at_limit();
        test_reset_mid_block();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
